// File: rtl/reg_bank_arbiter_pkg.sv
// reg_bank_arbiter_pkg: shared state encoding and default geometry for the register bank write port
package reg_bank_arbiter_pkg;
  typedef enum logic {ST_CLEAR = 1'b0, ST_IDLE = 1'b1} state_t;
  localparam int NUM_REGS_D = 8;
  localparam int ADDR_W_D = 3;
  localparam int DATA_W_D = 16;
endpackage

// File: rtl/reg_bank_arbiter_onehot_dec.sv
// reg_bank_arbiter_onehot_dec: row address to one-hot enable, flagging addresses that name a real row
module reg_bank_arbiter_onehot_dec #(
  parameter int NUM_REGS = 8,
  parameter int ADDR_W = 3
) (
  input  logic [ADDR_W-1:0]   addr,
  output logic [NUM_REGS-1:0] onehot,
  output logic                valid
);
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_dec
    assign onehot[i] = addr == ADDR_W'(i);
  end
  assign valid = {1'b0, addr} < (ADDR_W + 1)'(NUM_REGS);
endmodule

// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: round-robin write arbiter for core and debug ports with a zero-clear sweep of the bank
module reg_bank_arbiter
  import reg_bank_arbiter_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_D,
  parameter int ADDR_W = ADDR_W_D,
  parameter int DATA_W = DATA_W_D
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                a_req,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [DATA_W-1:0]   a_data,
  output logic                a_gnt,
  input  logic                b_req,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [DATA_W-1:0]   b_data,
  output logic                b_gnt,
  input  logic                clr_req,
  output logic [NUM_REGS-1:0] wr_en,
  output logic [DATA_W-1:0]   wr_data,
  output logic                ready,
  output logic                addr_err
);
  state_t state, state_n;
  logic [ADDR_W-1:0] cnt, cnt_n, dec_addr;
  logic last_b, last_b_n, last, pick_b, win, dec_valid;
  logic [NUM_REGS-1:0] dec_oh, en_n;
  logic [DATA_W-1:0] data_n;
  logic a_gnt_n, b_gnt_n, ready_n, err_n;
  assign last = cnt == ADDR_W'(NUM_REGS - 1);
  assign pick_b = b_req & (~a_req | ~last_b);
  assign win = (state == ST_IDLE) & ~clr_req & (a_req | b_req);
  assign dec_addr = state == ST_CLEAR ? cnt : pick_b ? b_addr : a_addr;
  reg_bank_arbiter_onehot_dec #(.NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) u_dec (
    .addr(dec_addr),
    .onehot(dec_oh),
    .valid(dec_valid)
  );
  // next state and next registered outputs; the decoder serves the sweep row or the winner's row
  always_comb begin
    state_n = state == ST_CLEAR ? (last ? ST_IDLE : ST_CLEAR) : (clr_req ? ST_CLEAR : ST_IDLE);
    cnt_n = (state == ST_CLEAR) & ~last ? cnt + 1'b1 : '0;
    last_b_n = win ? pick_b : last_b;
    en_n = (state == ST_CLEAR) | (win & dec_valid) ? dec_oh : '0;
    data_n = state == ST_CLEAR ? '0 : win ? (pick_b ? b_data : a_data) : wr_data;
    a_gnt_n = win & ~pick_b;
    b_gnt_n = win & pick_b;
    ready_n = (state == ST_IDLE) & ~clr_req;
    err_n = win & ~dec_valid;
  end
  // all state and outputs registered; reset restarts the sweep and cancels any grant
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_CLEAR;
      cnt <= '0;
      last_b <= 1'b0;
      wr_en <= '0;
      wr_data <= '0;
      a_gnt <= 1'b0;
      b_gnt <= 1'b0;
      ready <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      last_b <= last_b_n;
      wr_en <= en_n;
      wr_data <= data_n;
      a_gnt <= a_gnt_n;
      b_gnt <= b_gnt_n;
      ready <= ready_n;
      addr_err <= err_n;
    end
  end
endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb_reg_bank_arbiter: directed and random checks of 8-row and 6-row arbiters against a behavioural model
module tb_reg_bank_arbiter;
  logic clk = 1'b0;
  logic rst, a_req, b_req, clr_req;
  logic [2:0] a_addr, b_addr;
  logic [15:0] a_data, b_data;
  logic u8_ag, u8_bg, u8_rdy, u8_err, u6_ag, u6_bg, u6_rdy, u6_err;
  logic [7:0] u8_en;
  logic [5:0] u6_en;
  logic [15:0] u8_data, u6_data;
  int checks = 0;
  int errors = 0;
  int sweep [2] = '{0, 0};
  bit lb [2];
  logic [7:0] e_en [2];
  logic [15:0] e_data [2];
  bit e_ag [2], e_bg [2], e_rdy [2], e_err [2];

  always #5 clk = ~clk;

  reg_bank_arbiter u8 (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_gnt(u8_ag),
    .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_gnt(u8_bg),
    .clr_req(clr_req), .wr_en(u8_en), .wr_data(u8_data), .ready(u8_rdy), .addr_err(u8_err)
  );

  reg_bank_arbiter #(.NUM_REGS(6)) u6 (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_gnt(u6_ag),
    .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_gnt(u6_bg),
    .clr_req(clr_req), .wr_en(u6_en), .wr_data(u6_data), .ready(u6_rdy), .addr_err(u6_err)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int n, ad;
      bit bw;
      n = k ? 6 : 8;
      e_ag[k] = 0; e_bg[k] = 0; e_err[k] = 0; e_rdy[k] = 0; e_en[k] = '0;
      if (rst) begin
        sweep[k] = 0;
        lb[k] = 0;
        e_data[k] = '0;
      end else if (sweep[k] < n) begin
        e_en[k] = 8'(1 << sweep[k]);
        e_data[k] = '0;
        sweep[k]++;
      end else if (clr_req) begin
        sweep[k] = 0;
      end else begin
        e_rdy[k] = 1;
        if (a_req || b_req) begin
          bw = b_req && !(a_req && lb[k]);
          ad = bw ? int'(b_addr) : int'(a_addr);
          e_data[k] = bw ? b_data : a_data;
          e_ag[k] = !bw;
          e_bg[k] = bw;
          lb[k] = bw;
          e_en[k] = ad < n ? 8'(1 << ad) : 8'h00;
          e_err[k] = ad >= n;
        end
      end
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("u8.wr_en", {8'h00, u8_en}, {8'h00, e_en[0]});
    chk("u8.wr_data", u8_data, e_data[0]);
    chk("u8.a_gnt", {15'd0, u8_ag}, {15'd0, e_ag[0]});
    chk("u8.b_gnt", {15'd0, u8_bg}, {15'd0, e_bg[0]});
    chk("u8.ready", {15'd0, u8_rdy}, {15'd0, e_rdy[0]});
    chk("u8.addr_err", {15'd0, u8_err}, {15'd0, e_err[0]});
    chk("u6.wr_en", {10'd0, u6_en}, {8'h00, e_en[1]});
    chk("u6.wr_data", u6_data, e_data[1]);
    chk("u6.a_gnt", {15'd0, u6_ag}, {15'd0, e_ag[1]});
    chk("u6.b_gnt", {15'd0, u6_bg}, {15'd0, e_bg[1]});
    chk("u6.ready", {15'd0, u6_rdy}, {15'd0, e_rdy[1]});
    chk("u6.addr_err", {15'd0, u6_err}, {15'd0, e_err[1]});
  endtask

  initial begin
    rst = 1; a_req = 0; b_req = 0; clr_req = 0;
    a_addr = 0; b_addr = 0; a_data = 0; b_data = 0;
    step();
    step();
    chk("reset.wr_en", {8'h00, u8_en}, 16'h0000);
    chk("reset.ready", {15'd0, u8_rdy}, 16'h0000);
    rst = 0; a_req = 1; a_addr = 3; a_data = 16'hBEEF;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("sweep.walk", {8'h00, u8_en}, 16'(1 << i));
      chk("sweep.no_gnt", {15'd0, u8_ag}, 16'h0000);
    end
    step();
    chk("first.ready", {15'd0, u8_rdy}, 16'h0001);
    chk("first.a_gnt", {15'd0, u8_ag}, 16'h0001);
    chk("first.wr_en", {8'h00, u8_en}, 16'h0008);
    chk("first.wr_data", u8_data, 16'hBEEF);
    a_req = 0;
    step();
    a_req = 1; b_req = 1; a_addr = 1; b_addr = 2; a_data = 16'hAAAA; b_data = 16'hBBBB;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("contend.b_first", {15'd0, u8_bg}, 16'(i % 2 == 0));
      chk("contend.data", u8_data, i % 2 == 0 ? 16'hBBBB : 16'hAAAA);
    end
    a_req = 0; b_addr = 7; b_data = 16'h1234;
    step();
    chk("oob.u6_err", {15'd0, u6_err}, 16'h0001);
    chk("oob.u6_en", {10'd0, u6_en}, 16'h0000);
    chk("oob.u8_en", {8'h00, u8_en}, 16'h0080);
    b_req = 0; a_req = 1; a_addr = 4;
    step();
    chk("midgrant.a_gnt", {15'd0, u8_ag}, 16'h0001);
    rst = 1;
    step();
    rst = 0;
    step();
    chk("restart.wr_en", {8'h00, u8_en}, 16'h0001);
    a_req = 0;
    for (int i = 0; i < 9; i++) step();
    a_req = 1; clr_req = 1;
    step();
    chk("clr.no_gnt", {15'd0, u8_ag}, 16'h0000);
    clr_req = 0; a_req = 0;
    step();
    chk("clr.sweep", {8'h00, u8_en}, 16'h0001);
    for (int i = 0; i < 400; i++) begin
      a_req = 1'($urandom_range(0, 1));
      b_req = 1'($urandom_range(0, 1));
      a_addr = 3'($urandom);
      b_addr = 3'($urandom);
      a_data = 16'($urandom);
      b_data = 16'($urandom);
      clr_req = $urandom_range(0, 31) == 0;
      rst = $urandom_range(0, 63) == 0;
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
